// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited req/gnt/rvalid fetch, fetch FIFO, IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch/stall/flush performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_pc,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic        if_id_valid_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned PW = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FBUF_DEPTH + 1);
    localparam logic [CW:0]  DEPTH_C = (CW+1)'(FBUF_DEPTH);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] fb_wptr_q, fb_wptr_d, fb_rptr_q, fb_rptr_d;
    logic [PW-1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
    logic [31:0]   ir_q, ir_d, ipc_q, ipc_d, inpc_q, inpc_d;
    logic          valid_q, valid_d;

    logic [31:0]   fb_ir  [FBUF_DEPTH];
    logic [31:0]   fb_pc  [FBUF_DEPTH];
    logic [31:0]   tag_pc [FBUF_DEPTH];

    logic          rsp_ok, fire, fb_push, fb_pop;
    logic [CW:0]   in_use;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok    = imem_rvalid & (out_q != '0);
    assign in_use    = {1'b0, fcnt_q} + {1'b0, out_q};
    assign imem_req  = ~ex_take_branch & (in_use < DEPTH_C);
    assign imem_addr = pc_q;
    assign fire      = imem_req & imem_gnt;
    assign fb_push   = rsp_ok & ~ex_take_branch & (drop_q == '0);
    assign fb_pop    = ~ex_take_branch & ~id_stall & (fcnt_q != '0);

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        fcnt_d     = fcnt_q;
        fb_wptr_d  = fb_wptr_q;
        fb_rptr_d  = fb_rptr_q;
        out_d      = out_q + CW'(fire) - CW'(rsp_ok);
        tag_wptr_d = fire   ? ptr_inc(tag_wptr_q) : tag_wptr_q;
        tag_rptr_d = rsp_ok ? ptr_inc(tag_rptr_q) : tag_rptr_q;
        if (ex_take_branch) begin
            pc_d      = ex_target_pc;
            drop_d    = out_q - CW'(rsp_ok);
            fcnt_d    = '0;
            fb_wptr_d = '0;
            fb_rptr_d = '0;
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_ok && drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
            fcnt_d = fcnt_q + CW'(fb_push) - CW'(fb_pop);
            if (fb_push) begin
                fb_wptr_d = ptr_inc(fb_wptr_q);
            end
            if (fb_pop) begin
                fb_rptr_d = ptr_inc(fb_rptr_q);
            end
        end
    end

    // Redirect wins over stall so decode never sees a wrong-path instruction.
    always_comb begin
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        inpc_d  = inpc_q;
        valid_d = valid_q;
        if (ex_take_branch) begin
            valid_d = 1'b0;
            ir_d    = NOP;
        end else if (!id_stall) begin
            if (fcnt_q != '0) begin
                ir_d    = fb_ir[fb_rptr_q];
                ipc_d   = fb_pc[fb_rptr_q];
                inpc_d  = fb_pc[fb_rptr_q] + 32'd4;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
                ir_d    = NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            fcnt_q     <= '0;
            fb_wptr_q  <= '0;
            fb_rptr_q  <= '0;
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
            ir_q       <= NOP;
            ipc_q      <= '0;
            inpc_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fcnt_q     <= fcnt_d;
            fb_wptr_q  <= fb_wptr_d;
            fb_rptr_q  <= fb_rptr_d;
            tag_wptr_q <= tag_wptr_d;
            tag_rptr_q <= tag_rptr_d;
            ir_q       <= ir_d;
            ipc_q      <= ipc_d;
            inpc_q     <= inpc_d;
            valid_q    <= valid_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (fb_push) begin
            fb_ir[fb_wptr_q] <= imem_rdata;
            fb_pc[fb_wptr_q] <= tag_pc[tag_rptr_q];
        end
        if (fire) begin
            tag_pc[tag_wptr_q] <= pc_q;
        end
    end

    assign if_id_IR         = ir_q;
    assign if_id_PC         = ipc_q;
    assign if_id_NPC        = inpc_q;
    assign if_id_valid_inst = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] pf_fetch_q, pf_stall_q, pf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_fetch_q <= '0;
            pf_stall_q <= '0;
            pf_flush_q <= '0;
        end else begin
            pf_fetch_q <= pf_fetch_q + 32'(fb_pop);
            pf_stall_q <= pf_stall_q + 32'(id_stall & valid_q);
            pf_flush_q <= pf_flush_q + 32'(ex_take_branch);
        end
    end

    assign perf_fetch_cnt = pf_fetch_q;
    assign perf_stall_cnt = pf_stall_q;
    assign perf_flush_cnt = pf_flush_q;
`endif

    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (out_q != '0));

endmodule
